// File: rtl/ex_stage.sv
`timescale 1ns/1ps
// ex_stage -- execute stage of the five-stage pipeline.
//
// Holds the ID->EX input register and computes the ALU result from it
// combinationally, so EX results leave in the same cycle the instruction sits here.
// The stage also drives the data SRAM request and forwards results to decode.
//
// Optional feature (macro MULDIV_EN): mult/multu write {hi, lo} in a single
// cycle. div/divu use a 32-cycle radix-2 restoring divider that holds the
// pipeline through stallreq_ex. Without the macro, md_op is ignored and
// hi/lo/stallreq_ex are tied to zero.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0]          per-stage stall vector (bit2 = this register, bit3 = MEM)
//   id_to_ex_bus[158:0] decoded instruction from ID
//   md_op[3:0]          one-hot {div, divu, mult, multu}
//   ex_to_mem_bus[75:0] {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus[37:0]  {we, waddr, wdata} forwarding path to decode
//   ex_is_load          instruction in EX reads memory (load-use hazard)
//   data_sram_*         data memory request
//   stallreq_ex         EX asks the pipeline to hold
//   hi, lo              HI/LO registers
//   dbg_div_state_o     divider FSM state (0 idle, 1 busy, 2 done)
//
// Handshake: there is no valid/ready pair. The stall vector is the only flow
// control. stall[2]=0 loads a new instruction. stall[2]=1 with stall[3]=0
// inserts a bubble. stall[2]=1 with stall[3]=1 holds the current instruction.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  input  logic [3:0]   md_op,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         ex_is_load,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_ex,
  output logic [31:0]  hi,
  output logic [31:0]  lo,
  output logic [1:0]   dbg_div_state_o
);

  // ---------------- input register ----------------
  logic [158:0] bus_q, bus_d;
  logic [3:0]   md_q, md_d;

  always_comb begin
    bus_d = bus_q;
    md_d  = md_q;
    if (!stall[2]) begin
      bus_d = id_to_ex_bus;
      md_d  = md_op;
    end else if (!stall[3]) begin
      bus_d = '0;
      md_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
      md_q  <= '0;
    end else begin
      bus_q <= bus_d;
      md_q  <= md_d;
    end
  end

  // ---------------- field extraction ----------------
  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign pc         = bus_q[158:127];
  assign inst       = bus_q[126:95];
  assign alu_op     = bus_q[94:83];
  assign sel_src1   = bus_q[82:80];
  assign sel_src2   = bus_q[79:76];
  assign ram_en     = bus_q[75];
  assign ram_wen    = bus_q[74:71];
  assign rf_we      = bus_q[70];
  assign rf_waddr   = bus_q[69:65];
  assign sel_rf_res = bus_q[64];
  assign rs_data    = bus_q[63:32];
  assign rt_data    = bus_q[31:0];

  // ---------------- ALU ----------------
  logic [31:0] src1, src2, alu_res;

  always_comb begin
    src1 = '0;
    if (sel_src1[0])      src1 = rs_data;
    else if (sel_src1[1]) src1 = pc;
    else if (sel_src1[2]) src1 = {27'd0, inst[10:6]};

    src2 = '0;
    if (sel_src2[0])      src2 = rt_data;
    else if (sel_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
    else if (sel_src2[2]) src2 = 32'd8;
    else if (sel_src2[3]) src2 = {16'd0, inst[15:0]};

    // alu_op is one-hot, MSB first; all-zero yields 0
    alu_res = '0;
    if (alu_op[11])      alu_res = src1 + src2;
    else if (alu_op[10]) alu_res = src1 - src2;
    else if (alu_op[9])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[8])  alu_res = {31'd0, src1 < src2};
    else if (alu_op[7])  alu_res = src1 & src2;
    else if (alu_op[6])  alu_res = ~(src1 | src2);
    else if (alu_op[5])  alu_res = src1 | src2;
    else if (alu_op[4])  alu_res = src1 ^ src2;
    else if (alu_op[3])  alu_res = src2 << src1[4:0];
    else if (alu_op[2])  alu_res = src2 >> src1[4:0];
    else if (alu_op[1])  alu_res = $signed(src2) >>> src1[4:0];
    else if (alu_op[0])  alu_res = {src2[15:0], 16'h0};
  end

  // ---------------- outputs ----------------
  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, alu_res};
  // loads write the register file from MEM, so they are not forwarded here
  assign ex_to_rf_bus    = {rf_we & ~sel_rf_res, rf_waddr, alu_res};
  assign ex_is_load      = sel_rf_res;
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rt_data;

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[31:16], inst[5:0]};

`ifdef MULDIV_EN
  // ---------------- multiply / divide ----------------
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_div, div_signed, is_mult, reg_update, stall_div;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] shifted, diff;

  assign is_div     = md_q[3] | md_q[2];
  assign div_signed = md_q[3];
  assign is_mult    = md_q[1] | md_q[0];
  assign reg_update = ~stall[2] | ~stall[3];

  // Sign-extend for mult, zero-extend for multu; the low 64 bits of the
  // product are then correct for both.
  assign mul_a = {{32{md_q[1] & rs_data[31]}}, rs_data};
  assign mul_b = {{32{md_q[1] & rt_data[31]}}, rt_data};
  assign prod  = mul_a * mul_b;

  // one restoring step: shift in next dividend bit, subtract if it fits
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = done_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_div = 1'b0;

    if (is_mult && !stall[3]) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end

    case (state_q)
      DIV_IDLE: begin
        // done_q blocks a restart while a finished divide is still held in EX
        if (is_div && !done_q) begin
          stall_div = 1'b1;
          if (rt_data == 32'd0) begin
            // divide by zero: result registers preloaded, no iterations
            rem_d     = rs_data;
            quo_d     = 32'hFFFF_FFFF;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = (div_signed && rs_data[31]) ? -rs_data : rs_data;
            dvs_d     = (div_signed && rt_data[31]) ? -rt_data : rt_data;
            neg_quo_d = div_signed & (rs_data[31] ^ rt_data[31]);
            neg_rem_d = div_signed & rs_data[31];
            cnt_d     = '0;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        stall_div = 1'b1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (reg_update) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stallreq_ex     = stall_div;
  assign hi              = hi_q;
  assign lo              = lo_q;
  assign dbg_div_state_o = state_q;
`else
  logic unused_md;
  assign unused_md       = ^md_q;
  assign stallreq_ex     = 1'b0;
  assign hi              = '0;
  assign lo              = '0;
  assign dbg_div_state_o = 2'd0;
`endif

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 stall  in  6  per-stage stall vector; bit2 = EX input register, bit3 = MEM.
REQ-004 id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_data[63:32], rt_data[31:0]}.
REQ-005 md_op  in  4  one-hot {div, divu, mult, multu}; registered alongside id_to_ex_bus.
REQ-006 ex_to_mem_bus  out  76  {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-007 ex_to_rf_bus  out  38  {we, waddr, wdata} forwarding to decode.
REQ-008 ex_is_load  out  1  registered sel_rf_res; used by decode for load-use stall.
REQ-009 data_sram_en / data_sram_wen / data_sram_addr / data_sram_wdata  out  1/4/32/32  data memory request.
REQ-010 stallreq_ex  out  1  EX requests pipeline hold.
REQ-011 hi, lo  out  32 each  HI/LO registers.

Function
REQ-012 Input register: rst -> all zero; stall[2]=1 and stall[3]=0 -> load zero (bubble); stall[2]=0 -> load inputs; otherwise hold.
REQ-013 alu_op one-hot, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; all-zero -> result 0.
REQ-014 src1 one-hot: [0] rs_data, [1] pc, [2] zero-extended inst[10:6]; src2 one-hot: [0] rt_data, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0]; none selected -> operand 0.
REQ-015 add/sub modulo 2^32, no overflow trap; slt signed, sltu unsigned, result 1/0; shifts = src2 shifted by src1[4:0] (sra arithmetic); lui = {src2[15:0], 16'h0}.
REQ-016 ex_result = ALU result, combinational from registered state (zero added latency).
REQ-017 data_sram_en = ram_en, data_sram_wen = ram_wen, data_sram_addr = ex_result, data_sram_wdata = rt_data.
REQ-018 ex_to_rf_bus: we = rf_we AND NOT sel_rf_res, waddr = rf_waddr, wdata = ex_result.
REQ-019 Bubble (all-zero register) produces no write, no memory request, stallreq_ex=0.

Reset
REQ-020 On rst: input register, hi, lo, divider state, done flag all zero/IDLE; every output 0 on the following cycle.
REQ-021 rst mid-divide aborts the divide; hi/lo are not updated.

Configuration
REQ-022 Macro MULDIV_EN defined: REQ-023..REQ-027 apply.
REQ-023 mult/multu: 64-bit signed/unsigned product of rs_data x rt_data written {hi, lo} at the clock edge ending the cycle the op is in EX with stall[3]=0; no stall.
REQ-024 div/divu: radix-2 restoring divider, FSM IDLE -> BUSY (32 cycles) -> DONE -> IDLE; stallreq_ex=1 from the first EX cycle through the last BUSY cycle, 0 in DONE; lo = quotient, hi = remainder, written at DONE.
REQ-025 Signed div: operate on magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-026 Divide by zero: BUSY skipped (IDLE -> DONE), 1 stall cycle; lo = 32'hFFFFFFFF, hi = rs_data.
REQ-027 Done flag set at DONE, cleared when the input register loads; a divide does not restart while the flag is set (held by downstream stall).
REQ-028 MULDIV_EN undefined: md_op ignored, no FSM or HI/LO logic, stallreq_ex tied 0, hi = lo = 0.

Verification
REQ-029 addu rs=0x7FFFFFFF, rt=1, rd=5 -> ex_result 0x80000000, ex_to_rf_bus {1, 5, 0x80000000} same cycle.
REQ-030 sw base=0x1000, offset=-4, rt=0xA5A5A5A5 -> data_sram_addr 0x0FFC, wen 4'hF, wdata 0xA5A5A5A5; lw -> ex_to_rf we=0, ex_is_load=1.
REQ-031 stall=6'b000100 with valid addu -> next cycle all outputs 0; stall=6'b001100 -> register holds previous instruction.
REQ-032 (MULDIV_EN) div rs=-7, rt=2 -> stallreq_ex high 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/0 -> 1 stall cycle, lo=0xFFFFFFFF, hi=100.
REQ-033 (MULDIV_EN) mult 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same -> hi=1, lo=0xFFFFFFFE.
REQ-034 rst asserted at BUSY cycle 10 -> next cycle IDLE, stallreq_ex=0, hi=lo=0.
